// File: rtl/comp_gt8_serial.sv
// Bit-serial MSB-first unsigned magnitude comparator with a start/done handshake.
// Operands are latched on an accepted start; gt/lt/eq are held until the next accepted start.
module comp_gt8_serial #(
  parameter int W          = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         gt,
  output logic         lt,
  output logic         eq
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  sa_r, sa_s;
  logic [W-1:0]  sb_r, sb_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          dgt_r, dgt_s;
  logic          dlt_r, dlt_s;
  logic          gt_r, gt_s;
  logic          lt_r, lt_s;
  logic          eq_r, eq_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          diff_s;

  assign diff_s = sa_r[W-1] ^ sb_r[W-1];

  // Next-state, datapath and flag computation.
  always_comb begin
    state_s = state_r;
    sa_s    = sa_r;
    sb_s    = sb_r;
    cnt_s   = cnt_r;
    dgt_s   = dgt_r;
    dlt_s   = dlt_r;
    gt_s    = gt_r;
    lt_s    = lt_r;
    eq_s    = eq_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          sa_s    = a;
          sb_s    = b;
          cnt_s   = CW'(W - 1);
          dgt_s   = 1'b0;
          dlt_s   = 1'b0;
          gt_s    = 1'b0;
          lt_s    = 1'b0;
          eq_s    = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sa_s  = {sa_r[W-2:0], 1'b0};
        sb_s  = {sb_r[W-2:0], 1'b0};
        cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        // Only the first (most significant) difference decides the result.
        if (diff_s && !(dgt_r || dlt_r)) begin
          dgt_s = sa_r[W-1];
          dlt_s = sb_r[W-1];
        end else begin
          dgt_s = dgt_r;
          dlt_s = dlt_r;
        end
        if ((diff_s && EARLY_EXIT) || (cnt_r == {CW{1'b0}})) begin
          state_s = DONE;
          cnt_s   = {CW{1'b0}};
          gt_s    = dgt_s;
          lt_s    = dlt_s;
          eq_s    = !(dgt_s || dlt_s);
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      sa_r    <= {W{1'b0}};
      sb_r    <= {W{1'b0}};
      cnt_r   <= {CW{1'b0}};
      dgt_r   <= 1'b0;
      dlt_r   <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      eq_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sa_r    <= sa_s;
      sb_r    <= sb_s;
      cnt_r   <= cnt_s;
      dgt_r   <= dgt_s;
      dlt_r   <= dlt_s;
      gt_r    <= gt_s;
      lt_r    <= lt_s;
      eq_r    <= eq_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign gt   = gt_r;
  assign lt   = lt_r;
  assign eq   = eq_r;

endmodule

// File: doc/comp_gt8_serial.md
Name: comp_gt8_serial

Overview:
- Sequential, bit-serial magnitude comparator for W-bit unsigned operands.
- A start/done handshake drives it. It is the serial counterpart of the parallel 8-bit greater-than comparator.
- Used in the pong datapath where comparisons are infrequent and area matters, for example score and limit checks.
- Operands are latched on start and scanned MSB-first. Result flags gt/lt/eq are produced, with optional early termination on the first differing bit.

Parameters:
W, 8, operand width in bits (W >= 2)
EARLY_EXIT, 1, 1 = finish on first differing bit; 0 = always scan all W bits (fixed latency)

Ports:
clk  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
a  in  W  operand A, unsigned, sampled on accepted start
b  in  W  operand B, unsigned, sampled on accepted start
busy  out  1  high in SHIFT and DONE states
done  out  1  one-cycle pulse, result valid
gt  out  1  a > b
lt  out  1  a < b
eq  out  1  a == b

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE immediately.
  - busy=0, done=0, gt=0, lt=0, eq=0.
  - Shift registers and bit counter clear.
  - A reset mid-operation aborts the compare; no done pulse is produced.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - On a clock edge E0 with start=1, latch a and b into shift registers sa and sb.
  - Load the counter with W-1, clear gt/lt/eq, and go to SHIFT.
  - start=0 stays in IDLE. Flags hold their last result.
- SHIFT: each edge compares sa[W-1] with sb[W-1].
  - If the bits differ and EARLY_EXIT=1, set gt=sa[W-1] and lt=sb[W-1], then go to DONE.
  - If the bits differ and EARLY_EXIT=0, record the decision in internal sticky flags. The first difference wins; later bits are ignored.
  - After each compare, shift sa and sb left by 1 and decrement the counter.
  - When the counter reaches 0 (the LSB has been compared), go to DONE.
  - Outputs at DONE entry: gt/lt come from the decision; eq=1 if no difference was found.
- DONE:
  - done=1 for exactly one cycle; next edge goes to IDLE.
  - gt/lt/eq are registered and held until the next accepted start.
- Exactly one of gt/lt/eq is high after any done. All three are 0 from reset until the first done.
- Latency:
  - Let n be the number of compare edges. n = W - k, where k is the index of the highest differing bit with EARLY_EXIT=1. Otherwise n = W.
  - done is high in the cycle after edge E0+n.
  - busy is high from after E0 through the done cycle.
- start while busy (SHIFT or DONE) is ignored and not queued. start in the same cycle that done is high is also ignored.
- a/b changing after E0 has no effect on the result.
- Back-to-back throughput: the next start is accepted one cycle after done, in IDLE.

Test Plan:
- Reset and idle check:
  - Assert reset_n=0 mid-SHIFT (a=100, b=101, 3 edges in) -> busy=0, done=0, flags=0 immediately, and no done pulse after release.
  - With reset_n released and start held 0 for 10 cycles -> outputs stay 0.
- EARLY_EXIT=1, MSB and mid-bit differences:
  - a=128, b=0 -> done after n=1 compare edge, gt=1 lt=0 eq=0.
  - a=2, b=1 -> n=7, gt=1.
  - a=1, b=2 -> n=7, lt=1.
- Equal and LSB-only difference:
  - a=3, b=3 -> n=8, eq=1.
  - a=100, b=101 -> n=8, lt=1.
  - a=101, b=100 -> n=8, gt=1.
  - a=103, b=102 -> n=8, gt=1.
- EARLY_EXIT=0 instance:
  - a=128, b=0 and a=102, b=103 -> both take n=8.
  - Results are gt=1 and lt=1 respectively.
  - Later differing bits do not override the first difference (a=0x80, b=0x7F -> gt=1).
- Handshake abuse:
  - Pulse start with a=1, b=2 during SHIFT of (a=2, b=1) -> ignored; result gt=1, a single done.
  - start held high continuously -> a new compare starts one cycle after each done.
  - a/b are changed after E0 -> result still matches the latched values.
